prbs_core_lfsr: RTL and testbench
=================================

Name: prbs_core_lfsr

Overview:
- Single-bit pseudo-random binary sequence (PRBS) generator in the DAC clock domain.
- Implements a selectable-length Fibonacci LFSR (PN3 to PN31).
- Advances one bit per cycle in which the upstream rate divider asserts an enable.
- Emits the serial PRBS bit plus a one-cycle flag marking the end of each full sequence period.

Parameters:
- SEED, 31'h7FFF_FFFF, LFSR load value; only the low N bits of the active length are used; must be non-zero in those bits.

Ports:
- dac_clk  input  1  DAC clock (625 MHz nominal); all logic is rising-edge.
- reset_n  input  1  synchronous, active-high reset despite the suffix (codebase name retained); sampled on the dac_clk rising edge.
- lfsr_clk_enable  input  1  advance LFSR by one bit this cycle.
- prbs_pn_select_reg  input  4  sequence select.
- prbs_bit_out  output  1  registered PRBS bit.
- data_valid  output  1  one-cycle pulse at each completed sequence period.

Behaviour:
- One clock (dac_clk); reset is synchronous and active-high.
- Select decode (N = length, T = tap):
  - 0: PN3 (x^3+x^2+1; N=3, T=2)
  - 1: PN7 (x^7+x^6+1)
  - 2: PN9 (x^9+x^5+1)
  - 3: PN11 (x^11+x^9+1)
  - 4: PN15 (x^15+x^14+1)
  - 5: PN20 (x^20+x^17+1)
  - 6: PN23 (x^23+x^18+1)
  - 7: PN31 (x^31+x^28+1)
  - 8 to 15: reserved, decode as PN7.
- State: 31-bit register s; only s[N-1:0] is significant.
- Advance, on a rising edge with lfsr_clk_enable=1 and no reload:
  - fb = s[N-1] ^ s[T-1]
  - s[N-1:0] <= {s[N-2:0], fb}
  - prbs_bit_out <= s[N-1], i.e. the pre-shift MSB; latency is 1 cycle from enable to output.
- lfsr_clk_enable=0: state, prbs_bit_out and the period tracking hold; data_valid=0.
- Period flag: data_valid <= 1 for exactly one cycle on the advance whose next state equals SEED[N-1:0]. This happens every 2^N-1 advances, the first time on advance number 2^N-1 after reset or reload. Otherwise data_valid <= 0.
- Select change:
  - Module keeps a latched copy sel_q.
  - When prbs_pn_select_reg != sel_q on a clock edge: sel_q <= new value, s <= SEED, prbs_bit_out <= 0, data_valid <= 0.
  - Any simultaneous enable is ignored that cycle; reload has priority over advance.
- Reset (reset_n=1 at an edge): s <= SEED, sel_q <= prbs_pn_select_reg, prbs_bit_out <= 0, data_valid <= 0.
  - Reset has priority over reload and enable.
  - Reset mid-sequence restarts from SEED.
- Lock-up: an all-zero state is unreachable with a non-zero SEED; no extra recovery logic is required.
- Expected PN3 output from SEED all-ones: 1,1,1,0,0,1,0, repeating. Per period: 4 ones, 3 zeros.
- PN7 output from all-ones: first 7 bits are 1; each 127-bit period holds 64 ones and 63 zeros.

Test Plan:
- Reset, select=0, enable pulsed 1 cycle high / 1 cycle low ×7 -> prbs_bit_out sequence 1,1,1,0,0,1,0; data_valid pulses once, one cycle after the 7th enable edge.
- Same setup, 100 enable pulses -> 58 ones, 42 zeros; 14 data_valid pulses, each exactly one cycle wide.
- Switch select 0->1 mid-stream, then 127 enables -> first 7 bits are 1; 64 ones, 63 zeros; exactly one data_valid, on the 127th advance; no pulse during the reload cycle.
- Hold lfsr_clk_enable=0 for 50 cycles mid-sequence -> prbs_bit_out and state frozen; data_valid stays 0; sequence resumes where it stopped.
- Assert reset_n=1 for one edge after 3 PN3 bits -> prbs_bit_out=0 and data_valid=0 next cycle; next enables reproduce 1,1,1,0,...
- Select 7 (PN31) for 10,000 enables -> no data_valid; output never stuck at a constant; select 12 reproduces the PN7 sequence exactly.

Source files
------------

// File: rtl/prbs_core_lfsr.sv
// Selectable-length Fibonacci LFSR (PN3..PN31) in the DAC clock domain.
// Emits one PRBS bit per enabled cycle plus an end-of-period pulse.
module prbs_core_lfsr #(
  parameter logic [30:0] SEED = 31'h7FFF_FFFF
) (
  input  logic       dac_clk,
  input  logic       reset_n,
  input  logic       lfsr_clk_enable,
  input  logic [3:0] prbs_pn_select_reg,
  output logic       prbs_bit_out,
  output logic       data_valid
);

  logic [3:0]  sel_q;
  logic [30:0] s;
  logic [30:0] s_nxt;
  logic [30:0] mask;
  logic [4:0]  len;
  logic [4:0]  tap;
  logic        msb;
  logic        fb;
  logic        wrap;
  logic        reload;

  // Reserved selects fall through to PN7.
  always_comb begin
    len = 5'd7;
    tap = 5'd6;
    case (sel_q)
      4'd0: begin len = 5'd3;  tap = 5'd2;  end
      4'd1: begin len = 5'd7;  tap = 5'd6;  end
      4'd2: begin len = 5'd9;  tap = 5'd5;  end
      4'd3: begin len = 5'd11; tap = 5'd9;  end
      4'd4: begin len = 5'd15; tap = 5'd14; end
      4'd5: begin len = 5'd20; tap = 5'd17; end
      4'd6: begin len = 5'd23; tap = 5'd18; end
      4'd7: begin len = 5'd31; tap = 5'd28; end
      default: begin
        len = 5'd7;
        tap = 5'd6;
      end
    endcase
  end

  always_comb begin
    mask   = 31'h7FFF_FFFF >> (5'd31 - len);
    msb    = s[len - 5'd1];
    fb     = msb ^ s[tap - 5'd1];
    s_nxt  = {s[29:0], fb} & mask;
    wrap   = (s_nxt == (SEED & mask));
    reload = (prbs_pn_select_reg != sel_q);
  end

  // Reset beats reload, reload beats advance.
  always_ff @(posedge dac_clk) begin
    if (reset_n) begin
      s            <= SEED;
      sel_q        <= prbs_pn_select_reg;
      prbs_bit_out <= 1'b0;
      data_valid   <= 1'b0;
    end else if (reload) begin
      s            <= SEED;
      sel_q        <= prbs_pn_select_reg;
      prbs_bit_out <= 1'b0;
      data_valid   <= 1'b0;
    end else if (lfsr_clk_enable) begin
      s            <= s_nxt;
      prbs_bit_out <= msb;
      data_valid   <= wrap;
    end else begin
      data_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prbs_core_lfsr.sv
// Bench for prbs_core_lfsr: per-cycle model compare plus
// directed sequence/count checks with hand-derived values.
module tb_prbs_core_lfsr;

  logic       dac_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] sel = 4'd0;
  logic       bit_o;
  logic       dv;

  prbs_core_lfsr dut (
    .dac_clk(dac_clk),
    .reset_n(reset_n),
    .lfsr_clk_enable(en),
    .prbs_pn_select_reg(sel),
    .prbs_bit_out(bit_o),
    .data_valid(dv)
  );

  always #5 dac_clk = ~dac_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int n_of(input logic [3:0] v);
    case (v)
      4'd0: return 3;
      4'd1: return 7;
      4'd2: return 9;
      4'd3: return 11;
      4'd4: return 15;
      4'd5: return 20;
      4'd6: return 23;
      4'd7: return 31;
      default: return 7;
    endcase
  endfunction

  function automatic int t_of(input logic [3:0] v);
    case (v)
      4'd0: return 2;
      4'd1: return 6;
      4'd2: return 5;
      4'd3: return 9;
      4'd4: return 14;
      4'd5: return 17;
      4'd6: return 18;
      4'd7: return 28;
      default: return 6;
    endcase
  endfunction

  localparam longint SEEDV = 64'h7FFF_FFFF;

  function automatic longint seed_of(input logic [3:0] v);
    return SEEDV & ((64'd1 << n_of(v)) - 1);
  endfunction

  // Model: bits from integer LFSR arithmetic, period flag from advance count.
  bit         chk = 1'b0;
  logic [3:0] m_sel;
  longint     m_st;
  longint     m_cnt;
  longint     m_fb;
  bit         m_bit;
  bit         m_dv;
  int         mn;
  int         mt;

  always @(posedge dac_clk) begin
    if (reset_n) begin
      chk = 1'b1;
      m_sel = sel;
      m_st = seed_of(sel);
      m_bit = 1'b0;
      m_dv = 1'b0;
      m_cnt = 0;
    end else if (chk && sel != m_sel) begin
      m_sel = sel;
      m_st = seed_of(sel);
      m_bit = 1'b0;
      m_dv = 1'b0;
      m_cnt = 0;
    end else if (chk && en) begin
      mn = n_of(m_sel);
      mt = t_of(m_sel);
      m_bit = bit'((m_st >> (mn - 1)) & 1);
      m_fb = ((m_st >> (mn - 1)) ^ (m_st >> (mt - 1))) & 1;
      m_st = ((m_st << 1) | m_fb) & ((64'd1 << mn) - 1);
      m_cnt++;
      m_dv = (m_cnt % ((64'd1 << mn) - 1)) == 0;
    end else begin
      m_dv = 1'b0;
    end
  end

  always @(negedge dac_clk) begin
    if (chk) begin
      check("model_bit", longint'(bit_o), longint'(m_bit));
      check("model_dv", longint'(dv), longint'(m_dv));
    end
  end

  task automatic do_reset(input logic [3:0] s);
    @(negedge dac_clk);
    #1 reset_n = 1'b1;
    sel = s;
    en = 1'b0;
    @(negedge dac_clk);
    check("rst_bit", longint'(bit_o), 0);
    check("rst_dv", longint'(dv), 0);
    #1 reset_n = 1'b0;
  endtask

  task automatic pulse(output logic b, output logic v);
    @(negedge dac_clk);
    #1 en = 1'b1;
    @(negedge dac_clk);
    b = bit_o;
    v = dv;
    #1 en = 1'b0;
  endtask

  task automatic run(input int k, output int ones, output int dvs,
                     output int first7, output int last_dv);
    ones = 0;
    dvs = 0;
    first7 = 0;
    last_dv = 0;
    @(negedge dac_clk);
    #1 en = 1'b1;
    for (int i = 1; i <= k; i++) begin
      @(negedge dac_clk);
      if (bit_o) begin
        ones++;
        if (i <= 7) first7++;
      end
      if (dv) begin
        dvs++;
        last_dv = i;
      end
    end
    #1 en = 1'b0;
  endtask

  logic [6:0] seq;
  logic       b;
  logic       v;
  int         ones;
  int         dvs;
  int         dv_at;
  int         f7;
  int         chg;

  initial begin
    // PN3 first period
    do_reset(4'd0);
    seq = '0;
    dvs = 0;
    dv_at = 0;
    for (int i = 1; i <= 7; i++) begin
      pulse(b, v);
      seq = {seq[5:0], b};
      if (v) begin
        dvs++;
        dv_at = i;
      end
    end
    check("pn3_seq", longint'(seq), 64'b1110010);
    check("pn3_dv_cnt", dvs, 1);
    check("pn3_dv_at", dv_at, 7);

    // PN3 over 100 pulses
    do_reset(4'd0);
    ones = 0;
    dvs = 0;
    for (int i = 1; i <= 100; i++) begin
      pulse(b, v);
      if (b) ones++;
      if (v) dvs++;
    end
    check("pn3_100_ones", ones, 58);
    check("pn3_100_zeros", 100 - ones, 42);
    check("pn3_100_dv", dvs, 14);

    // select change mid-stream, with a coincident enable
    @(negedge dac_clk);
    #1 sel = 4'd1;
    en = 1'b1;
    @(negedge dac_clk);
    check("reload_bit", longint'(bit_o), 0);
    check("reload_dv", longint'(dv), 0);
    #1 en = 1'b0;
    run(127, ones, dvs, f7, dv_at);
    check("pn7_first7", f7, 7);
    check("pn7_ones", ones, 64);
    check("pn7_zeros", 127 - ones, 63);
    check("pn7_dv_cnt", dvs, 1);
    check("pn7_dv_at", dv_at, 127);

    // hold enable low mid-sequence
    do_reset(4'd0);
    seq = '0;
    for (int i = 0; i < 3; i++) begin
      pulse(b, v);
      seq = {seq[5:0], b};
    end
    chg = 0;
    dvs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge dac_clk);
      if (bit_o !== b) chg++;
      if (dv) dvs++;
    end
    check("hold_changes", chg, 0);
    check("hold_dv", dvs, 0);
    for (int i = 0; i < 4; i++) begin
      pulse(b, v);
      seq = {seq[5:0], b};
    end
    check("hold_resume_seq", longint'(seq), 64'b1110010);

    // reset mid-sequence
    do_reset(4'd0);
    for (int i = 0; i < 3; i++) pulse(b, v);
    do_reset(4'd0);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      pulse(b, v);
      seq = {seq[5:0], b};
    end
    check("rst_restart_seq", longint'(seq), 64'b0001110);

    // PN31 long run
    @(negedge dac_clk);
    #1 sel = 4'd7;
    run(10000, ones, dvs, f7, dv_at);
    check("pn31_dv", dvs, 0);
    check("pn31_first7", f7, 7);
    check("pn31_has_ones", longint'(ones > 0), 1);
    check("pn31_has_zeros", longint'(ones < 10000), 1);

    // reserved select decodes as PN7
    @(negedge dac_clk);
    #1 sel = 4'd12;
    run(127, ones, dvs, f7, dv_at);
    check("sel12_first7", f7, 7);
    check("sel12_ones", ones, 64);
    check("sel12_dv_cnt", dvs, 1);
    check("sel12_dv_at", dv_at, 127);

    repeat (3) @(negedge dac_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
